multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Parametrised multi-cycle MIPS control FSM, successor to the fixed-latency controller. It sequences fetch, decode, execute, memory, writeback and PC update. It also adds a ready-based memory handshake with timeout, N masked and prioritised interrupt lines, and reserved-instruction and bus-error exceptions. It sits between the IR/CP0 and the datapath muxes, register file, ALU and memory port.

## Interface
- N_IRQ, 6: number of interrupt lines, 1..32.
- TIMEOUT, 16: maximum wait cycles for `mem_rdy` before a bus error, at least 1.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op, funct  in  6 each  IR fields.
- rs  in  5  IR field, used to decode mfc0/mtc0.
- zero  in  1  ALU zero flag, used for beq.
- irq  in  N_IRQ  level interrupt requests.
- im  in  N_IRQ  CP0 interrupt mask.
- ie, exl  in  1 each  CP0 status bits.
- mem_rdy  in  1  memory completes the current request this cycle.
- mem_req, mem_we, mem_byte  out  1 each  memory strobe, write enable, byte access.
- ir_wr, pc_wr, reg_wr, alu_src, cp0_wr, exl_set, exl_clr  out  1 each.
- npc_sel  out  3  000 pc+4, 001 branch, 010 j/jal, 011 jr/jalr, 100 EPC, 101 exception vector.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- mem_to_reg  out  2  00 ALU, 01 memory, 10 pc+4, 11 CP0.
- ext_op  out  2  00 zero-extend, 01 sign-extend, 10 lui.
- alu_ctr  out  2  00 add, 01 sub, 10 or, 11 slt.
- exc_code  out  5  0 interrupt, 6 instruction bus error, 7 data bus error, 10 reserved instruction.
- irq_id  out  $clog2(N_IRQ) (minimum 1)  index of the serviced line.
- state  out  3  current state, for debug.

## Operation
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4, INT=5, EXC=6. `state` and the wait counter are registered. All other outputs decode combinationally from the state and IR fields; any output not stated active in a state is 0.
- Supported instructions: addu, subu, slt, jr, jalr, addi, addiu, ori, lui, lw, sw, lb, sb, beq, j, jal, eret, mfc0, mtc0. Any other encoding is reserved.
- IF: `mem_req`=1. When `mem_rdy`=1, `ir_wr`=1 and next state is ID. When `mem_rdy`=0, stay in IF.
- ID:
  - Reserved instruction: go to EXC with exc_code 10.
  - jal/jalr: `reg_wr`=1, `mem_to_reg`=10, `reg_dst`=10 for jal and 01 for jalr, then go to INT.
  - j, jr, eret: go to INT.
  - All other instructions: go to EXE.
- EXE: `alu_src`, `ext_op` and `alu_ctr` are valid.
  - lw/sw/lb/sb: go to MEM.
  - beq: go to INT.
  - mtc0: `cp0_wr`=1, then go to INT.
  - All other instructions: go to WB.
- MEM: `mem_req`=1. `mem_we`=1 for sw/sb; `mem_byte`=1 for lb/sb. Hold all of these until `mem_rdy`. On `mem_rdy`, loads go to WB and stores go to INT.
- WB: `reg_wr`=1. `mem_to_reg` is 01 for loads, 11 for mfc0, 00 otherwise. `reg_dst` is 01 for R-type, 00 otherwise. Then go to INT.
- INT: `pc_wr`=1, then go to IF.
  - pending = irq & im.
  - An interrupt is taken when ie=1, exl=0, pending≠0 and the instruction is not eret.
  - Taken: `npc_sel`=101, `exl_set`=1, `exc_code`=0, `irq_id` = lowest set index of pending (lowest index has highest priority).
  - Not taken: `npc_sel` is the instruction's next PC. beq uses 001 only when zero=1. eret uses 100 with `exl_clr`=1.
- EXC: `pc_wr`=1, `npc_sel`=101, `exl_set`=1, `exc_code` held from the faulting state, then go to IF. This is taken regardless of ie/exl.
- Wait counter:
  - Cleared on every entry to IF or MEM.
  - Increments each IF/MEM cycle with `mem_rdy`=0.
  - When count = TIMEOUT−1 and `mem_rdy`=0, go to EXC with code 6 (from IF) or 7 (from MEM).
  - In that cycle `mem_we` is still asserted; no further strobes follow.

## Timing
- Reset: the cycle after `rst` is sampled high, state=IF and the counter is 0. Outputs then read IF values: `mem_req`=1, all others 0, `exc_code`=0, `irq_id`=0. A reset mid-instruction abandons it: no `pc_wr` and no `reg_wr` are issued.
- With zero-wait memory (`mem_rdy` high on the first request cycle), per-instruction cycle counts are:
  - R-type/immediate/mfc0: 5.
  - lw/lb: 6.
  - sw/sb: 5.
  - beq/mtc0: 4.
  - j/jal/jr/jalr/eret: 3.
  - Each memory wait cycle adds 1.
- `pc_wr` is exactly one cycle per instruction, or per exception.
- `mem_rdy` arriving in the timeout cycle wins: the access completes normally.
- Interrupt and eret in the same INT cycle: eret executes and the interrupt is deferred to the next instruction's INT.
- `irq`, `im`, `ie` and `exl` are sampled only in INT. Pulses that occur outside INT are ignored.

## Test plan
- Reset, then addu with `mem_rdy`=1: states 0,1,2,4,5,0. `reg_wr`=1 only in WB with `reg_dst`=01. `pc_wr` once, `npc_sel`=000.
- lw with `mem_rdy` low for 3 MEM cycles, TIMEOUT=16: MEM lasts 4 cycles with `mem_req`=1 throughout, then WB with `mem_to_reg`=01. Total 9 cycles.
- sw with `mem_rdy` never asserted, TIMEOUT=4: `mem_we`=1 for 4 cycles, then EXC with `exc_code`=7, `pc_wr`=1, `npc_sel`=101, `exl_set`=1, then IF.
- op=6'b111111: ID goes to EXC with `exc_code`=10. No `reg_wr`.
- N_IRQ=6, irq=6'b101000, im=6'b111000, ie=1, exl=0 at beq INT: `npc_sel`=101, `irq_id`=3, `exc_code`=0. Repeat with exl=1: `npc_sel`=001 when zero=1.
- eret with an interrupt pending: INT shows `npc_sel`=100 and `exl_clr`=1, no `exl_set`. Assert `rst` in a WB cycle: next cycle state=0 and `reg_wr`=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS control FSM.
//
// Sequences IF -> ID -> EXE -> MEM -> WB -> INT (PC update) with an EXC
// state for reserved instructions and memory bus errors.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   op, funct, rs      IR fields used for decode
//   zero               ALU zero flag (beq)
//   irq, im            level interrupt requests and CP0 mask
//   ie, exl            CP0 status bits
//   mem_rdy            memory completes the current request this cycle
//   mem_req/we/byte    memory strobe, write enable, byte access
//   ir_wr, pc_wr, reg_wr, alu_src, cp0_wr, exl_set, exl_clr   datapath strobes
//   npc_sel, reg_dst, mem_to_reg, ext_op, alu_ctr             datapath mux selects
//   exc_code, irq_id   exception cause and serviced interrupt line
//   state              current FSM state (debug)
//
// Memory handshake: a request is outstanding for every cycle mem_req is 1
// and completes on the cycle mem_rdy is 1 (no separate accept phase). If
// mem_rdy has not arrived by the TIMEOUT-th cycle of a request, the access
// is abandoned and a bus-error exception is raised; mem_rdy in that last
// cycle still completes the access.
module multicycle_ctrl #(
    parameter int N_IRQ   = 6,
    parameter int TIMEOUT = 16,
    localparam int IDW    = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic [4:0]       rs,
    input  logic             zero,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] im,
    input  logic             ie,
    input  logic             exl,
    input  logic             mem_rdy,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_byte,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic             reg_wr,
    output logic             alu_src,
    output logic             cp0_wr,
    output logic             exl_set,
    output logic             exl_clr,
    output logic [2:0]       npc_sel,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       ext_op,
    output logic [1:0]       alu_ctr,
    output logic [4:0]       exc_code,
    output logic [IDW-1:0]   irq_id,
    output logic [2:0]       state
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_INT = 3'd5,
        S_EXC = 3'd6
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      exc_q, exc_d;

    // Instruction decode
    logic is_r, is_cop0;
    logic is_addu, is_subu, is_slt, is_jr, is_jalr;
    logic is_addi, is_addiu, is_ori, is_lui, is_lw, is_sw, is_lb, is_sb;
    logic is_beq, is_j, is_jal, is_eret, is_mfc0, is_mtc0;
    logic is_load, is_store, is_valid;

    assign is_r     = (op == 6'h00);
    assign is_cop0  = (op == 6'h10);
    assign is_addu  = is_r && (funct == 6'h21);
    assign is_subu  = is_r && (funct == 6'h23);
    assign is_slt   = is_r && (funct == 6'h2a);
    assign is_jr    = is_r && (funct == 6'h08);
    assign is_jalr  = is_r && (funct == 6'h09);
    assign is_addi  = (op == 6'h08);
    assign is_addiu = (op == 6'h09);
    assign is_ori   = (op == 6'h0d);
    assign is_lui   = (op == 6'h0f);
    assign is_lw    = (op == 6'h23);
    assign is_sw    = (op == 6'h2b);
    assign is_lb    = (op == 6'h20);
    assign is_sb    = (op == 6'h28);
    assign is_beq   = (op == 6'h04);
    assign is_j     = (op == 6'h02);
    assign is_jal   = (op == 6'h03);
    assign is_mfc0  = is_cop0 && (rs == 5'h00);
    assign is_mtc0  = is_cop0 && (rs == 5'h04);
    assign is_eret  = is_cop0 && (rs == 5'h10) && (funct == 6'h18);
    assign is_load  = is_lw || is_lb;
    assign is_store = is_sw || is_sb;
    assign is_valid = is_addu || is_subu || is_slt || is_jr || is_jalr ||
                      is_addi || is_addiu || is_ori || is_lui ||
                      is_load || is_store || is_beq || is_j || is_jal ||
                      is_eret || is_mfc0 || is_mtc0;

    // Interrupt priority: lowest pending index wins
    logic [N_IRQ-1:0] pending;
    logic [IDW-1:0]   low_id;
    logic             irq_take;

    assign pending  = irq & im;
    assign irq_take = ie && !exl && (pending != '0) && !is_eret;

    always_comb begin
        low_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) low_id = IDW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            cnt_q   <= '0;
            exc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;      // the counter only survives while waiting in IF/MEM
        exc_d      = exc_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_byte   = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        reg_wr     = 1'b0;
        alu_src    = 1'b0;
        cp0_wr     = 1'b0;
        exl_set    = 1'b0;
        exl_clr    = 1'b0;
        npc_sel    = 3'b000;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        ext_op     = 2'b00;
        alu_ctr    = 2'b00;
        exc_code   = 5'd0;
        irq_id     = '0;

        case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                if (mem_rdy) begin
                    ir_wr   = 1'b1;
                    state_d = S_ID;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_EXC;
                    exc_d   = 5'd6;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ID: begin
                if (!is_valid) begin
                    state_d = S_EXC;
                    exc_d   = 5'd10;
                end else if (is_jal || is_jalr) begin
                    reg_wr     = 1'b1;
                    mem_to_reg = 2'b10;
                    reg_dst    = is_jal ? 2'b10 : 2'b01;
                    state_d    = S_INT;
                end else if (is_j || is_jr || is_eret) begin
                    state_d = S_INT;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                if (is_subu || is_beq) alu_ctr = 2'b01;
                else if (is_slt)       alu_ctr = 2'b11;
                else if (is_ori)       alu_ctr = 2'b10;
                // lui: extender places imm in the upper half, added to rs ($0)
                if (is_addi || is_addiu || is_load || is_store) begin
                    alu_src = 1'b1;
                    ext_op  = 2'b01;
                end else if (is_ori) begin
                    alu_src = 1'b1;
                end else if (is_lui) begin
                    alu_src = 1'b1;
                    ext_op  = 2'b10;
                end
                if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_beq) begin
                    state_d = S_INT;
                end else if (is_mtc0) begin
                    cp0_wr  = 1'b1;
                    state_d = S_INT;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = is_store;
                mem_byte = is_lb || is_sb;
                if (mem_rdy) begin
                    state_d = is_load ? S_WB : S_INT;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_EXC;
                    exc_d   = 5'd7;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = is_load ? 2'b01 : (is_mfc0 ? 2'b11 : 2'b00);
                reg_dst    = is_r ? 2'b01 : 2'b00;
                state_d    = S_INT;
            end
            S_INT: begin
                pc_wr   = 1'b1;
                state_d = S_IF;
                if (irq_take) begin
                    npc_sel = 3'b101;
                    exl_set = 1'b1;
                    irq_id  = low_id;
                end else if (is_beq) begin
                    npc_sel = zero ? 3'b001 : 3'b000;
                end else if (is_j || is_jal) begin
                    npc_sel = 3'b010;
                end else if (is_jr || is_jalr) begin
                    npc_sel = 3'b011;
                end else if (is_eret) begin
                    npc_sel = 3'b100;
                    exl_clr = 1'b1;
                end
            end
            S_EXC: begin
                pc_wr    = 1'b1;
                npc_sel  = 3'b101;
                exl_set  = 1'b1;
                exc_code = exc_q;
                state_d  = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: per-instruction expected traces are built
// from the instruction's documented cycle sequence, then replayed cycle by
// cycle against the DUT.
module tb_multicycle_ctrl;

  localparam int N_IRQ   = 6;
  localparam int TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, zero, ie, exl, mem_rdy;
  logic [5:0] op, funct;
  logic [4:0] rs;
  logic [N_IRQ-1:0] irq, im;
  logic mem_req, mem_we, mem_byte, ir_wr, pc_wr, reg_wr, alu_src, cp0_wr, exl_set, exl_clr;
  logic [2:0] npc_sel, state;
  logic [1:0] reg_dst, mem_to_reg, ext_op, alu_ctr;
  logic [4:0] exc_code;
  logic [2:0] irq_id;

  multicycle_ctrl #(.N_IRQ(N_IRQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .rs(rs), .zero(zero),
    .irq(irq), .im(im), .ie(ie), .exl(exl), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .ir_wr(ir_wr),
    .pc_wr(pc_wr), .reg_wr(reg_wr), .alu_src(alu_src), .cp0_wr(cp0_wr),
    .exl_set(exl_set), .exl_clr(exl_clr), .npc_sel(npc_sel), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .ext_op(ext_op), .alu_ctr(alu_ctr),
    .exc_code(exc_code), .irq_id(irq_id), .state(state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic mem_req, mem_we, mem_byte, ir_wr, pc_wr, reg_wr, alu_src, cp0_wr, exl_set, exl_clr;
    logic [2:0] npc_sel;
    logic [1:0] reg_dst, mem_to_reg, ext_op, alu_ctr;
    logic [4:0] exc_code;
    logic [2:0] irq_id;
  } outs_t;

  outs_t obs;
  assign obs = {state, mem_req, mem_we, mem_byte, ir_wr, pc_wr, reg_wr, alu_src, cp0_wr,
                exl_set, exl_clr, npc_sel, reg_dst, mem_to_reg, ext_op, alu_ctr, exc_code, irq_id};

  typedef struct {
    logic rst, chk, rdy, zero, ie, exl;
    logic [5:0] irq, im, op, funct;
    logic [4:0] rs;
    outs_t exp;
  } step_t;

  step_t exp_q[$];

  typedef enum int {
    K_ADDU, K_SUBU, K_SLT, K_JR, K_JALR, K_ADDI, K_ADDIU, K_ORI, K_LUI, K_LW,
    K_SW, K_LB, K_SB, K_BEQ, K_J, K_JAL, K_ERET, K_MFC0, K_MTC0, K_RSV
  } kind_e;

  // ---------------- scoreboard counters / check ----------------
  int n_cmp = 0;
  int n_err = 0;
  int step_idx = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", tag, step_idx, got, exp);
    end
  endtask

  // ---------------- reference model: trace builder ----------------
  logic [5:0] cur_op, cur_funct;
  logic [4:0] cur_rs;
  logic [5:0] g_irq, g_im;
  logic       g_ie, g_exl, g_zero;

  function automatic outs_t blank(input logic [2:0] st);
    outs_t o = '0;
    o.st = st;
    return o;
  endfunction

  // INT steps carry the chosen interrupt/zero inputs; every other step gets noise.
  task automatic push(input outs_t e, input logic rdy, input logic int_step);
    step_t s;
    s.rst = 1'b0; s.chk = 1'b1; s.rdy = rdy;
    s.op = cur_op; s.funct = cur_funct; s.rs = cur_rs;
    if (int_step) begin
      s.irq = g_irq; s.im = g_im; s.ie = g_ie; s.exl = g_exl; s.zero = g_zero;
    end else begin
      s.irq = 6'($urandom); s.im = 6'($urandom);
      s.ie = 1'($urandom); s.exl = 1'($urandom); s.zero = 1'($urandom);
    end
    s.exp = e;
    exp_q.push_back(s);
  endtask

  task automatic push_rst();
    step_t s;
    s = '{rst: 1'b1, chk: 1'b0, rdy: 1'b0, zero: 1'b0, ie: 1'b0, exl: 1'b0,
          irq: '0, im: '0, op: '0, funct: '0, rs: '0, exp: '0};
    exp_q.push_back(s);
  endtask

  task automatic set_enc(input kind_e k);
    cur_op = 6'h00; cur_funct = 6'($urandom); cur_rs = 5'($urandom);
    case (k)
      K_ADDU:  cur_funct = 6'h21;
      K_SUBU:  cur_funct = 6'h23;
      K_SLT:   cur_funct = 6'h2a;
      K_JR:    cur_funct = 6'h08;
      K_JALR:  cur_funct = 6'h09;
      K_ADDI:  cur_op = 6'h08;
      K_ADDIU: cur_op = 6'h09;
      K_ORI:   cur_op = 6'h0d;
      K_LUI:   cur_op = 6'h0f;
      K_LW:    cur_op = 6'h23;
      K_SW:    cur_op = 6'h2b;
      K_LB:    cur_op = 6'h20;
      K_SB:    cur_op = 6'h28;
      K_BEQ:   cur_op = 6'h04;
      K_J:     cur_op = 6'h02;
      K_JAL:   cur_op = 6'h03;
      K_ERET:  begin cur_op = 6'h10; cur_rs = 5'h10; cur_funct = 6'h18; end
      K_MFC0:  begin cur_op = 6'h10; cur_rs = 5'h00; end
      K_MTC0:  begin cur_op = 6'h10; cur_rs = 5'h04; end
      default: begin
        case ($urandom_range(0, 3))
          0: cur_op = 6'h3f;
          1: cur_funct = 6'h20;                               // add (trapping) unsupported
          2: begin cur_op = 6'h10; cur_rs = 5'h01; end
          default: begin cur_op = 6'h10; cur_rs = 5'h10; cur_funct = 6'h01; end
        endcase
      end
    endcase
  endtask

  task automatic exc_step(input logic [4:0] code);
    outs_t o = blank(3'd6);
    o.pc_wr = 1'b1; o.npc_sel = 3'b101; o.exl_set = 1'b1; o.exc_code = code;
    push(o, 1'($urandom), 1'b0);
  endtask

  task automatic int_step(input kind_e k);
    outs_t o = blank(3'd5);
    logic [5:0] pend;
    o.pc_wr = 1'b1;
    pend = g_irq & g_im;
    if (g_ie && !g_exl && pend != 0 && k != K_ERET) begin
      o.npc_sel = 3'b101; o.exl_set = 1'b1;
      for (int i = N_IRQ - 1; i >= 0; i--) if (pend[i]) o.irq_id = 3'(i);
    end else begin
      case (k)
        K_BEQ:        o.npc_sel = g_zero ? 3'b001 : 3'b000;
        K_J, K_JAL:   o.npc_sel = 3'b010;
        K_JR, K_JALR: o.npc_sel = 3'b011;
        K_ERET:       begin o.npc_sel = 3'b100; o.exl_clr = 1'b1; end
        default:      o.npc_sel = 3'b000;
      endcase
    end
    push(o, 1'($urandom), 1'b1);
  endtask

  // Returns 1 when the access completed, 0 when it timed out (EXC already pushed).
  task automatic mem_phase(input logic [2:0] st, input int wait_n, input logic we,
                           input logic by, input logic [4:0] code, output logic ok);
    outs_t o;
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      o = blank(st); o.mem_req = 1'b1; o.mem_we = we; o.mem_byte = by;
      if (i >= wait_n) begin
        if (st == 3'd0) o.ir_wr = 1'b1;
        push(o, 1'b1, 1'b0);
        ok = 1'b1;
        break;
      end
      push(o, 1'b0, 1'b0);
    end
    if (!ok) exc_step(code);
  endtask

  task automatic gen_instr(input kind_e k, input int if_wait, input int mem_wait);
    outs_t o;
    logic ok, is_ld, is_st;
    set_enc(k);
    is_ld = (k == K_LW || k == K_LB);
    is_st = (k == K_SW || k == K_SB);
    mem_phase(3'd0, if_wait, 1'b0, 1'b0, 5'd6, ok);
    if (!ok) return;
    o = blank(3'd1);
    if (k == K_RSV) begin
      push(o, 1'($urandom), 1'b0); exc_step(5'd10); return;
    end
    if (k == K_JAL || k == K_JALR) begin
      o.reg_wr = 1'b1; o.mem_to_reg = 2'b10; o.reg_dst = (k == K_JAL) ? 2'b10 : 2'b01;
    end
    push(o, 1'($urandom), 1'b0);
    if (k == K_JAL || k == K_JALR || k == K_J || k == K_JR || k == K_ERET) begin
      int_step(k); return;
    end
    o = blank(3'd2);
    case (k)
      K_SUBU:  o.alu_ctr = 2'b01;
      K_SLT:   o.alu_ctr = 2'b11;
      K_BEQ:   o.alu_ctr = 2'b01;
      K_ADDI, K_ADDIU, K_LW, K_SW, K_LB, K_SB: begin o.alu_src = 1'b1; o.ext_op = 2'b01; end
      K_ORI:   begin o.alu_src = 1'b1; o.alu_ctr = 2'b10; end
      K_LUI:   begin o.alu_src = 1'b1; o.ext_op = 2'b10; end
      K_MTC0:  o.cp0_wr = 1'b1;
      default: ;
    endcase
    push(o, 1'($urandom), 1'b0);
    if (k == K_BEQ || k == K_MTC0) begin int_step(k); return; end
    if (is_ld || is_st) begin
      mem_phase(3'd3, mem_wait, is_st, (k == K_LB || k == K_SB), 5'd7, ok);
      if (!ok) return;
      if (is_st) begin int_step(k); return; end
    end
    o = blank(3'd4);
    o.reg_wr = 1'b1;
    o.mem_to_reg = is_ld ? 2'b01 : ((k == K_MFC0) ? 2'b11 : 2'b00);
    o.reg_dst = (k == K_ADDU || k == K_SUBU || k == K_SLT) ? 2'b01 : 2'b00;
    push(o, 1'($urandom), 1'b0);
    int_step(k);
  endtask

  task automatic set_int(input logic [5:0] i_irq, input logic [5:0] i_im,
                         input logic i_ie, input logic i_exl, input logic i_zero);
    g_irq = i_irq; g_im = i_im; g_ie = i_ie; g_exl = i_exl; g_zero = i_zero;
  endtask

  function automatic int rnd_wait();
    return ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TIMEOUT + 1)) : 0;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_step(input step_t s);
    @(negedge clk);
    rst = s.rst; mem_rdy = s.rdy; zero = s.zero; irq = s.irq; im = s.im;
    ie = s.ie; exl = s.exl; op = s.op; funct = s.funct; rs = s.rs;
    #2;
    if (s.chk) check("cyc", obs, s.exp);
    step_idx++;
  endtask

  initial begin
    step_t s;
    rst = 1'b1; mem_rdy = 1'b0; zero = 1'b0; irq = '0; im = '0; ie = 1'b0; exl = 1'b0;
    op = '0; funct = '0; rs = '0;

    push_rst(); push_rst();
    // addu, zero-wait memory, no interrupt
    set_int(6'b0, 6'b0, 1'b0, 1'b0, 1'b0);
    gen_instr(K_ADDU, 0, 0);
    // lw with 3 MEM wait cycles: ready arrives in the timeout cycle and wins
    gen_instr(K_LW, 0, 3);
    // sw that never completes: bus error 7
    gen_instr(K_SW, 0, 100);
    // fetch timeout: bus error 6
    gen_instr(K_ADDU, 100, 0);
    // reserved instruction
    gen_instr(K_RSV, 0, 0);
    // beq with interrupt taken, then masked by exl
    set_int(6'b101000, 6'b111000, 1'b1, 1'b0, 1'b1);
    gen_instr(K_BEQ, 0, 0);
    set_int(6'b101000, 6'b111000, 1'b1, 1'b1, 1'b1);
    gen_instr(K_BEQ, 0, 0);
    // eret with interrupt pending: eret wins
    set_int(6'b000001, 6'b111111, 1'b1, 1'b0, 1'b0);
    gen_instr(K_ERET, 1, 0);
    // reset during WB abandons the instruction: drop INT, assert rst in WB
    set_int(6'b0, 6'b0, 1'b0, 1'b0, 1'b0);
    gen_instr(K_ADDU, 0, 0);
    void'(exp_q.pop_back());
    s = exp_q.pop_back();
    s.rst = 1'b1;
    exp_q.push_back(s);
    // randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      set_int(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      gen_instr(kind_e'($urandom_range(0, 19)), rnd_wait(), rnd_wait());
    end

    while (exp_q.size() > 0) drive_step(exp_q.pop_front());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
